qspi_target: RTL and testbench

- Quad-SPI responder (target) for the SoC's QSPI master protocol. Used as an on-chip memory-backed target and as a PSRAM/flash stand-in for system benches.
- Decodes command 0xEB (quad read: mode plus dummy cycles) and 0x38 (quad write).
- Services both commands from a byte-wide synchronous memory port.
- Oversamples the QSPI pins in the clk domain.

---
 rtl/qspi_target.sv | 241 ++++++++++++++++++++++++
 tb/tb_qspi_target.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_target.sv
// Quad-SPI target (responder) for the SoC QSPI master protocol.
// Serves quad read (READ_CMD, with mode/dummy clocks) and quad write (WRITE_CMD) from a
// byte-wide synchronous memory port. All QSPI pins are oversampled in the clk domain,
// so clk must run at least 8x faster than spi_clk.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   spi_clk_i         QSPI clock from the master (mode 0, idles low)
//   spi_cs_n_i        chip select, active low
//   spi_io_in_i       IO3..IO0 from the master
//   spi_io_out_o      IO3..IO0 driven by the target
//   spi_io_oe_o       per-line output enable (1 = drive)
//   mem_re_o          one-clk read strobe; mem_rdata_i is valid 1 clk later
//   mem_we_o          one-clk write strobe, with mem_wdata_o
//   mem_addr_o        byte address for mem_re_o / mem_we_o
//   busy_o            high while the synchronized chip select is asserted
module qspi_target #(
    parameter logic [7:0]  READ_CMD     = 8'hEB,
    parameter logic [7:0]  WRITE_CMD    = 8'h38,
    parameter int unsigned DUMMY_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk_i,
    input  logic        spi_cs_n_i,
    input  logic [3:0]  spi_io_in_i,
    output logic [3:0]  spi_io_out_o,
    output logic [3:0]  spi_io_oe_o,
    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic [23:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    output logic        busy_o
);

    localparam logic [7:0] DummyCnt = 8'(DUMMY_CYCLES);

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StDummy, StRData, StWData, StIgnore
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  sclk_q;
    logic [1:0]  cs_q;
    logic [3:0]  io_s1_q, io_s2_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        nib_q, nib_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        is_read_q, is_read_d;
    logic [23:0] addr_q, addr_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic [3:0]  whi_q, whi_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        re_q, re_d, we_q, we_d;
    logic        rd_pend_q;
    logic [7:0]  rbuf_q, rbuf_d;
    logic [3:0]  oe_q, oe_d, out_q, out_d;

    logic        rise, fall, cs_n_s;
    logic [7:0]  cmd_next;
    logic [23:0] addr_next;

    assign rise      = sclk_q[1] & ~sclk_q[2];
    assign fall      = ~sclk_q[1] & sclk_q[2];
    assign cs_n_s    = cs_q[1];
    assign cmd_next  = {cmd_q[6:0], io_s2_q[0]};
    assign addr_next = {addr_q[19:0], io_s2_q};

    // Synchronizers: io shares the clock's latency so it is sampled with the detected rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q  <= '0;
            cs_q    <= 2'b11;
            io_s1_q <= '0;
            io_s2_q <= '0;
        end else begin
            sclk_q  <= {sclk_q[1:0], spi_clk_i};
            cs_q    <= {cs_q[0], spi_cs_n_i};
            io_s1_q <= spi_io_in_i;
            io_s2_q <= io_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            nib_q      <= 1'b0;
            cmd_q      <= '0;
            is_read_q  <= 1'b0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            whi_q      <= '0;
            wdata_q    <= '0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            rd_pend_q  <= 1'b0;
            rbuf_q     <= '0;
            oe_q       <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nib_q      <= nib_d;
            cmd_q      <= cmd_d;
            is_read_q  <= is_read_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            whi_q      <= whi_d;
            wdata_q    <= wdata_d;
            re_q       <= re_d;
            we_q       <= we_d;
            rd_pend_q  <= re_q;
            rbuf_q     <= rbuf_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nib_d      = nib_q;
        cmd_d      = cmd_q;
        is_read_d  = is_read_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        whi_d      = whi_q;
        wdata_d    = wdata_q;
        re_d       = 1'b0;
        we_d       = 1'b0;
        rbuf_d     = rd_pend_q ? mem_rdata_i : rbuf_q;
        oe_d       = oe_q;
        out_d      = out_q;

        // A write is issued at the current address; advance it the clk after the strobe.
        if (we_q) begin
            mem_addr_d = mem_addr_q + 24'd1;
        end

        if (cs_n_s) begin
            state_d = StIdle;
            oe_d    = '0;
            out_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StCmd;
                    cnt_d   = '0;
                    nib_d   = 1'b0;
                end
                StCmd: begin
                    if (rise) begin
                        cmd_d = cmd_next;
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == 8'd7) begin
                            cnt_d = '0;
                            if (cmd_next == READ_CMD) begin
                                state_d   = StAddr;
                                is_read_d = 1'b1;
                            end else if (cmd_next == WRITE_CMD) begin
                                state_d   = StAddr;
                                is_read_d = 1'b0;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                StAddr: begin
                    if (rise) begin
                        addr_d = addr_next;
                        cnt_d  = cnt_q + 8'd1;
                        if (cnt_q == 8'd5) begin
                            cnt_d      = '0;
                            nib_d      = 1'b0;
                            mem_addr_d = addr_next;
                            if (is_read_q) begin
                                state_d = StDummy;
                                re_d    = 1'b1;
                            end else begin
                                state_d = StWData;
                            end
                        end
                    end
                end
                StDummy: begin
                    if (rise && cnt_q != DummyCnt) begin
                        cnt_d = cnt_q + 8'd1;
                    end else if (fall && cnt_q == DummyCnt) begin
                        // The entry fall already presents the first high nibble.
                        state_d = StRData;
                        oe_d    = 4'hF;
                        out_d   = rbuf_q[7:4];
                        nib_d   = 1'b1;
                    end
                end
                StRData: begin
                    if (fall) begin
                        oe_d = 4'hF;
                        if (!nib_q) begin
                            out_d = rbuf_q[7:4];
                            nib_d = 1'b1;
                        end else begin
                            out_d      = rbuf_q[3:0];
                            nib_d      = 1'b0;
                            mem_addr_d = mem_addr_q + 24'd1;
                            re_d       = 1'b1;
                        end
                    end
                end
                StWData: begin
                    if (rise) begin
                        if (!nib_q) begin
                            whi_d = io_s2_q;
                            nib_d = 1'b1;
                        end else begin
                            wdata_d = {whi_q, io_s2_q};
                            we_d    = 1'b1;
                            nib_d   = 1'b0;
                        end
                    end
                end
                StIgnore: begin
                    oe_d = '0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign spi_io_out_o = out_q;
    assign spi_io_oe_o  = oe_q;
    assign mem_re_o     = re_q;
    assign mem_we_o     = we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = wdata_q;
    assign busy_o       = ~cs_n_s;

endmodule

// File: tb/tb_qspi_target.sv
// Self-checking bench for qspi_target: a QSPI master model drives directed transactions,
// a byte memory model answers the memory port, and queues hold the expected memory
// strobes and read nibbles.
module tb_qspi_target;

    localparam int HALF = 80;  // half spi_clk period: spi_clk = clk / 16
    localparam int CLKP = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic [3:0]  spi_io_in = 4'h0;
    logic [3:0]  spi_io_out, spi_io_oe;
    logic        mem_re, mem_we, busy;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;
    int oe_viol = 0;
    bit oe_zero_req = 1'b0;

    logic [3:0]  exp_nib_q [$];
    logic [23:0] exp_re_q [$];
    logic [31:0] exp_we_q [$];

    qspi_target dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_clk_i    (spi_clk),
        .spi_cs_n_i   (spi_cs_n),
        .spi_io_in_i  (spi_io_in),
        .spi_io_out_o (spi_io_out),
        .spi_io_oe_o  (spi_io_oe),
        .mem_re_o     (mem_re),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .busy_o       (busy)
    );

    always #(CLKP / 2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Synchronous memory: data valid the clk after the read strobe.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[15:0]];
        if (mem_we) mem[mem_addr[15:0]] = mem_wdata;
    end

    // Scoreboard side: every memory strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (mem_re) begin
            check("we_with_re", {31'b0, mem_we}, 32'd0);
            if (exp_re_q.size() == 0) check("re_unexpected", {8'h0, mem_addr}, 32'hFFFF_FFFF);
            else check("re_addr", {8'h0, mem_addr}, {8'h0, exp_re_q.pop_front()});
        end
        if (mem_we) begin
            if (exp_we_q.size() == 0) check("we_unexpected", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            else check("we_addr_data", {mem_addr, mem_wdata}, exp_we_q.pop_front());
        end
        if (oe_zero_req && spi_io_oe !== 4'h0) oe_viol++;
    end

    task automatic spi_cycle(input logic [3:0] nib);
        spi_io_in = nib;
        #(HALF) spi_clk = 1'b1;
        #(HALF) spi_clk = 1'b0;
    endtask

    task automatic begin_txn();
        spi_cs_n = 1'b0;
        #(HALF);
        check("busy_in_txn", {31'b0, busy}, 32'd1);
    endtask

    task automatic end_txn();
        spi_io_in = 4'h0;
        #(HALF) spi_cs_n = 1'b1;
        #(20 * CLKP);
        check("oe_after_deselect", {28'b0, spi_io_oe}, 32'h0);
        check("out_after_deselect", {28'b0, spi_io_out}, 32'h0);
        check("busy_after_deselect", {31'b0, busy}, 32'd0);
        check("re_left", exp_re_q.size(), 32'd0);
        check("we_left", exp_we_q.size(), 32'd0);
        check("nib_left", exp_nib_q.size(), 32'd0);
        oe_zero_req = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) spi_cycle({3'b000, c[i]});
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) spi_cycle(a[i*4 +: 4]);
    endtask

    task automatic send_dummy();
        for (int i = 0; i < 6; i++) begin
            spi_io_in = 4'h0;
            #(HALF);
            check("oe_in_dummy", {28'b0, spi_io_oe}, 32'h0);
            spi_clk = 1'b1;
            #(HALF) spi_clk = 1'b0;
        end
    endtask

    // Master samples the target just before each rising edge.
    task automatic read_clocks(input int n);
        for (int i = 0; i < n; i++) begin
            #(HALF);
            check("rd_oe", {28'b0, spi_io_oe}, 32'hF);
            check("rd_nib", {28'b0, spi_io_out}, {28'b0, exp_nib_q.pop_front()});
            spi_clk = 1'b1;
            #(HALF) spi_clk = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0100] = 8'h11;
        mem[16'h0101] = 8'h22;
        mem[16'h0102] = 8'h33;
        mem[16'h0103] = 8'h44;
        mem[16'hFFFF] = 8'h5A;
        mem[16'h0000] = 8'hC3;

        repeat (3) @(negedge clk);
        check("rst_oe", {28'b0, spi_io_oe}, 32'h0);
        check("rst_out", {28'b0, spi_io_out}, 32'h0);
        check("rst_re_we", {30'b0, mem_re, mem_we}, 32'h0);
        check("rst_addr", {8'h0, mem_addr}, 32'h0);
        check("rst_wdata", {24'h0, mem_wdata}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        rst_n = 1'b1;
        #(10 * CLKP);

        // Quad read of 4 bytes at 0x100; the 4th low-nibble fall prefetches 0x104.
        exp_re_q = '{24'h000100, 24'h000101, 24'h000102, 24'h000103, 24'h000104};
        exp_nib_q = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};
        begin_txn();
        send_cmd(8'hEB);
        send_addr(24'h000100);
        send_dummy();
        read_clocks(8);
        end_txn();

        // Quad write of two bytes at 0xF0; target never drives.
        exp_we_q = '{{24'h0000F0, 8'hA5}, {24'h0000F1, 8'hC3}};
        oe_viol = 0;
        oe_zero_req = 1'b1;
        begin_txn();
        send_cmd(8'h38);
        send_addr(24'h0000F0);
        spi_cycle(4'hA);
        spi_cycle(4'h5);
        spi_cycle(4'hC);
        spi_cycle(4'h3);
        end_txn();
        check("write_oe_zero", oe_viol, 32'd0);

        // Address wrap: 4 data clocks cover 2 bytes, prefetching 0x000000 and 0x000001.
        exp_re_q = '{24'hFFFFFF, 24'h000000, 24'h000001};
        exp_nib_q = '{4'h5, 4'hA, 4'hC, 4'h3};
        begin_txn();
        send_cmd(8'hEB);
        send_addr(24'hFFFFFF);
        send_dummy();
        read_clocks(4);
        end_txn();

        // Unknown opcode: no drive, no memory traffic.
        oe_viol = 0;
        oe_zero_req = 1'b1;
        begin_txn();
        send_cmd(8'h9F);
        for (int i = 0; i < 16; i++) spi_cycle(4'($urandom_range(0, 15)));
        end_txn();
        check("ignore_oe_zero", oe_viol, 32'd0);

        // Abort after 3 nibbles: only the complete byte is written.
        exp_we_q = '{{24'h000200, 8'h7E}};
        begin_txn();
        send_cmd(8'h38);
        send_addr(24'h000200);
        spi_cycle(4'h7);
        spi_cycle(4'hE);
        spi_cycle(4'h1);
        end_txn();

        // Following read returns the byte just written.
        exp_re_q = '{24'h000200, 24'h000201};
        exp_nib_q = '{4'h7, 4'hE};
        begin_txn();
        send_cmd(8'hEB);
        send_addr(24'h000200);
        send_dummy();
        read_clocks(2);

        // Reset while in read data phase.
        #(HALF) rst_n = 1'b0;
        #(CLKP);
        check("rst_mid_oe", {28'b0, spi_io_oe}, 32'h0);
        check("rst_mid_out", {28'b0, spi_io_out}, 32'h0);
        check("rst_mid_addr", {8'h0, mem_addr}, 32'h0);
        check("rst_mid_busy", {31'b0, busy}, 32'h0);
        spi_cs_n = 1'b1;
        #(10 * CLKP) rst_n = 1'b1;
        #(10 * CLKP);
        check("rst_re_left", exp_re_q.size(), 32'd0);
        check("rst_nib_left", exp_nib_q.size(), 32'd0);

        // Transaction after reset decodes normally.
        exp_we_q = '{{24'h000300, 8'h12}, {24'h000301, 8'h34}};
        begin_txn();
        send_cmd(8'h38);
        send_addr(24'h000300);
        spi_cycle(4'h1);
        spi_cycle(4'h2);
        spi_cycle(4'h3);
        spi_cycle(4'h4);
        end_txn();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
